// File: rtl/enc16x4_seq.sv
// rtl/enc16x4_seq.sv - registered 16-to-4 priority encoder with valid/ready hand-off
//
// Latches request pulses into a pending register, presents the index of the
// highest-priority pending line as a 4-bit code, and clears that line when
// the consumer accepts it.
//
// Parameters:
//   HIGH_FIRST  1 = bit 15 has highest priority, 0 = bit 0 has highest priority
//   CNT_W       width of the grant counter (wraps modulo 2^CNT_W)
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req        request lines, a 1 on any edge sets the matching pending bit
//   ready      consumer accepts the code on an edge where valid && ready
//   code       index of the granted line (code[3] = A ... code[0] = D)
//   valid      code is meaningful and held
//   pending    current pending register
//   busy       |pending
//   grant_cnt  number of completed handshakes
module enc16x4_seq #(
  parameter bit HIGH_FIRST = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      req,
  input  logic             ready,
  output logic [3:0]       code,
  output logic             valid,
  output logic [15:0]      pending,
  output logic             busy,
  output logic [CNT_W-1:0] grant_cnt
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t      state;
  logic [3:0]  sel_idx;
  logic        accept;
  logic [15:0] clr_mask;

  // Priority pick over the registered pending value; later loop iterations
  // overwrite earlier ones, so the loop runs towards the winning end.
  always_comb begin
    sel_idx = 4'd0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 16; i++) begin
        if (pending[i]) sel_idx = 4'(i);
      end
    end else begin
      for (int i = 15; i >= 0; i--) begin
        if (pending[i]) sel_idx = 4'(i);
      end
    end
  end

  assign accept   = (state == PRESENT) && ready;
  assign clr_mask = accept ? (16'd1 << code) : 16'd0;
  assign busy     = |pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= 16'd0;
      code      <= 4'd0;
      valid     <= 1'b0;
      grant_cnt <= '0;
    end else begin
      // A request on the accepting edge re-sets the bit being cleared.
      pending <= (pending & ~clr_mask) | req;
      case (state)
        IDLE: begin
          if (|pending) begin
            code  <= sel_idx;
            valid <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          // No preemption: code is frozen until the consumer takes it.
          if (ready) begin
            grant_cnt <= grant_cnt + CNT_W'(1);
            valid     <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc16x4_seq.sv
// tb/tb_enc16x4_seq.sv - self-checking bench for enc16x4_seq (two parameter sets)
`timescale 1ns/1ps
module tb_enc16x4_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] req = 16'd0;
  logic        ready = 1'b0;

  logic [3:0]  code_a, code_b;
  logic        valid_a, valid_b;
  logic [15:0] pend_a, pend_b;
  logic        busy_a, busy_b;
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  enc16x4_seq #(.HIGH_FIRST(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .req(req), .ready(ready),
    .code(code_a), .valid(valid_a), .pending(pend_a), .busy(busy_a), .grant_cnt(cnt_a)
  );

  enc16x4_seq #(.HIGH_FIRST(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .req(req), .ready(ready),
    .code(code_b), .valid(valid_b), .pending(pend_b), .busy(busy_b), .grant_cnt(cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural reference of the 4-to-16 decoder that consumes the code.
  function automatic logic [15:0] dec(input logic [3:0] c);
    return 16'd1 << c;
  endfunction

  function automatic int pick(input logic [15:0] p, input bit hf);
    if (hf) begin
      for (int i = 15; i >= 0; i--) if (p[i]) return i;
    end else begin
      for (int i = 0; i < 16; i++) if (p[i]) return i;
    end
    return 0;
  endfunction

  // Reference model: index 0 = HIGH_FIRST=1/CNT_W=8, index 1 = HIGH_FIRST=0/CNT_W=2
  logic [15:0] m_pend[2];
  int          m_code[2];
  bit          m_valid[2];
  int          m_cnt[2];
  const bit    m_hf[2]   = '{1'b1, 1'b0};
  const int    m_cmod[2] = '{256, 4};

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_pend[k] = 16'd0; m_code[k] = 0; m_valid[k] = 1'b0; m_cnt[k] = 0;
      end else begin
        logic [15:0] np;
        np = m_pend[k];
        if (m_valid[k] && ready) begin
          np[m_code[k]] = 1'b0;
          m_valid[k] = 1'b0;
          m_cnt[k] = (m_cnt[k] + 1) % m_cmod[k];
        end else if (!m_valid[k] && m_pend[k] != 16'd0) begin
          m_code[k] = pick(m_pend[k], m_hf[k]);
          m_valid[k] = 1'b1;
        end
        m_pend[k] = np | req;
      end
    end
  end

  // Every-cycle comparison against the model, plus record of accepted codes.
  int acc_a[$];
  int acc_b[$];

  always @(negedge clk) begin
    chk("a.valid", 32'(valid_a), 32'(m_valid[0]));
    chk("a.pending", 32'(pend_a), 32'(m_pend[0]));
    chk("a.busy", 32'(busy_a), 32'(m_pend[0] != 16'd0));
    chk("a.cnt", 32'(cnt_a), 32'(m_cnt[0]));
    chk("a.code", 32'(code_a), 32'(m_code[0]));
    chk("b.valid", 32'(valid_b), 32'(m_valid[1]));
    chk("b.pending", 32'(pend_b), 32'(m_pend[1]));
    chk("b.busy", 32'(busy_b), 32'(m_pend[1] != 16'd0));
    chk("b.cnt", 32'(cnt_b), 32'(m_cnt[1]));
    chk("b.code", 32'(code_b), 32'(m_code[1]));
    if (!reset && valid_a && ready) acc_a.push_back(int'(code_a));
    if (!reset && valid_b && ready) acc_b.push_back(int'(code_b));
  end

  task automatic pulse(input logic [15:0] r);
    req = r;
    @(posedge clk); #1;
    req = 16'd0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt0;
    step(2);
    reset = 1'b0;
    chk("rst.valid", 32'(valid_a), 32'd0);
    chk("rst.pending", 32'(pend_a), 32'd0);
    chk("rst.cnt", 32'(cnt_a), 32'd0);

    // Asynchronous reset while a code is presented
    pulse(16'h8001);
    step(1);
    chk("pre.code_a", 32'(code_a), 32'd15);
    chk("pre.code_b", 32'(code_b), 32'd0);
    chk("pre.valid", 32'(valid_a), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst.valid", 32'(valid_a), 32'd0);
    chk("arst.code", 32'(code_a), 32'd0);
    chk("arst.pending", 32'(pend_a), 32'd0);
    chk("arst.busy", 32'(busy_a), 32'd0);
    chk("arst.pending_b", 32'(pend_b), 32'd0);
    step(1);
    reset = 1'b0;
    ready = 1'b1;
    step(3);
    chk("post.busy", 32'(busy_a), 32'd0);
    chk("post.valid", 32'(valid_a), 32'd0);
    chk("post.cnt", 32'(cnt_a), 32'd0);

    // Single-line sweep with ready tied high
    for (int i = 0; i < 16; i++) begin
      pulse(16'd1 << i);
      chk("sweep.early_valid", 32'(valid_a), 32'd0);
      step(1);
      chk("sweep.valid", 32'(valid_a), 32'd1);
      chk("sweep.code_a", 32'(code_a), 32'(i));
      chk("sweep.code_b", 32'(code_b), 32'(i));
      chk("sweep.dec", 32'(dec(code_a)), 32'(16'd1 << i));
      step(1);
      chk("sweep.drop", 32'(valid_a), 32'd0);
      chk("sweep.cnt_a", 32'(cnt_a), 32'(i + 1));
      if (i < 5) chk("wrap.cnt_b", 32'(cnt_b), 32'((i + 1) % 4));
    end
    chk("sweep.total", 32'(cnt_a), 32'd16);

    // Multi-hot burst, both priority directions
    acc_a.delete();
    acc_b.delete();
    pulse(16'hA005);
    chk("multi.pending", 32'(pend_a), 32'h0000A005);
    step(8);
    chk("multi.n_a", 32'(acc_a.size()), 32'd4);
    chk("multi.n_b", 32'(acc_b.size()), 32'd4);
    if (acc_a.size() == 4) begin
      chk("multi.a0", 32'(acc_a[0]), 32'd15);
      chk("multi.a1", 32'(acc_a[1]), 32'd13);
      chk("multi.a2", 32'(acc_a[2]), 32'd2);
      chk("multi.a3", 32'(acc_a[3]), 32'd0);
    end
    if (acc_b.size() == 4) begin
      chk("multi.b0", 32'(acc_b[0]), 32'd0);
      chk("multi.b1", 32'(acc_b[1]), 32'd2);
      chk("multi.b2", 32'(acc_b[2]), 32'd13);
      chk("multi.b3", 32'(acc_b[3]), 32'd15);
    end
    chk("multi.end_pending", 32'(pend_a), 32'd0);
    chk("multi.end_busy", 32'(busy_a), 32'd0);

    // Backpressure: a higher-priority request must not preempt
    ready = 1'b0;
    pulse(16'h0010);
    step(1);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) pulse(16'h8000);
      else step(1);
      chk("stall.code", 32'(code_a), 32'd4);
      chk("stall.valid", 32'(valid_a), 32'd1);
    end
    chk("stall.pending", 32'(pend_a), 32'h00008010);
    ready = 1'b1;
    step(1);
    chk("stall.accept", 32'(valid_a), 32'd0);
    step(1);
    chk("stall.next_code", 32'(code_a), 32'd15);
    chk("stall.next_valid", 32'(valid_a), 32'd1);
    step(2);

    // Set wins over clear on the accepting edge
    ready = 1'b0;
    pulse(16'h0008);
    step(1);
    chk("set.code", 32'(code_a), 32'd3);
    cnt0 = int'(cnt_a);
    ready = 1'b1;
    pulse(16'h0008);
    chk("set.keep", 32'(pend_a[3]), 32'd1);
    chk("set.drop", 32'(valid_a), 32'd0);
    step(1);
    chk("set.again", 32'(code_a), 32'd3);
    chk("set.again_valid", 32'(valid_a), 32'd1);
    step(1);
    chk("set.cnt", 32'(cnt_a), 32'((cnt0 + 2) % 256));
    chk("set.clear", 32'(pend_a), 32'd0);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/enc16x4_seq.md
# enc16x4_seq

Registered 16-to-4 priority encoder: the inverse of the team's 4-to-16 decoder (`DEC`, inputs A B C D, A = MSB). It latches one-hot or multi-hot request pulses on 16 lines into a pending register. It presents the index of the highest-priority pending line as a 4-bit code with a valid/ready handshake, and clears each line once its code is accepted. It sits in front of the decoder so that a decoded line can be re-encoded and handed off to a consumer.

## Interface
- HIGH_FIRST, 1, priority direction: 1 = bit 15 highest priority, 0 = bit 0 highest
- CNT_W, 8, width of the grant counter
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  16  request lines; a 1 on any edge sets the matching pending bit
- ready  input  1  consumer accepts the code on an edge where valid && ready
- code  output  4  encoded index of the granted line; A = code[3] … D = code[0], matching `DEC` input order
- valid  output  1  code is meaningful and held
- pending  output  16  current pending register
- busy  output  1  |pending (combinational from the register)
- grant_cnt  output  CNT_W  number of completed handshakes, wraps modulo 2^CNT_W

## Operation
- Reset (asynchronous, any time) drives the following:
  - pending=0, code=0, valid=0, grant_cnt=0, FSM=IDLE.
  - busy=0 follows from pending=0.
  - Reset mid-handshake discards the in-flight code; no grant is counted.
- Pending update on each edge: pending_next = (pending & ~clr_mask) | req.
  - clr_mask is one-hot at code only when valid && ready; otherwise it is 0.
  - If req[code] is 1 on the accepting edge, the bit stays set (set wins over clear).
- The FSM has two states: IDLE and PRESENT.
- IDLE:
  - If pending != 0:
    - Load code = priority index of pending (highest set bit if HIGH_FIRST=1, lowest otherwise).
    - Set valid=1 and go to PRESENT.
  - Requests arriving on this same edge are not considered until they appear in pending.
  - If pending == 0, stay in IDLE with valid=0; code holds its last value.
- PRESENT:
  - While ready=0, code and valid hold.
    - New higher-priority requests do not preempt; they only update pending.
  - On an edge with ready=1:
    - Clear the pending bit per the update rule above.
    - grant_cnt += 1 (wraps from 2^CNT_W-1 to 0).
    - Set valid=0 and return to IDLE.
- All outputs except busy are registered. code never changes while valid=1.

## Timing
- Request latency: req high for the cycle before edge k → pending bit set at edge k.
  - If the FSM is in IDLE after edge k: code/valid at edge k+1.
  - Minimum latency from req to valid is 2 edges.
- Handshake completes on the edge where valid && ready. valid is low for at least one cycle after every grant.
- Maximum throughput: one grant per 2 cycles with ready tied high.
- Multi-hot request: all bits latch on the same edge and are served in priority order. N simultaneous bits take 2N cycles to drain.
- Request pulse of exactly one cycle is never lost. A repeated pulse on an already-pending bit merges (no queuing depth beyond 1 per line).
- ready while valid=0 is ignored.

## Test plan
- Reset: assert reset asynchronously between edges while valid=1 with pending=16'h8001.
  - All outputs go to 0 immediately, with no clock edge needed.
  - After release, busy=0 and no grant is issued.
- Single line sweep: for i = 0..15, pulse req = 1<<i for one cycle with ready=1.
  - code = i with valid high exactly one cycle, 2 edges after the pulse.
  - Feeding code into `DEC` yields out = 1<<i.
  - grant_cnt = 16 at the end.
- Multi-hot, HIGH_FIRST=1: pulse req = 16'hA005 with ready=1.
  - Codes appear in order 15, 13, 2, 0, one every 2 cycles.
  - pending ends at 0 and busy falls after the last acceptance.
- Backpressure/no preemption: req = 16'h0010, hold ready=0 for 5 cycles, and pulse req = 16'h8000 during the stall.
  - code stays 4 for all 5 cycles.
  - After ready=1, the next grant is 15.
- Set-wins collision: while code=3 and valid=1, drive ready=1 and req = 16'h0008 on the same edge.
  - pending[3] stays 1.
  - code 3 is presented again 1 cycle later.
  - grant_cnt increments once per acceptance.
- Counter wrap with CNT_W=2: complete 5 grants; grant_cnt reads 1, 2, 3, 0, 1.
  - Repeat the multi-hot test with HIGH_FIRST=0: order 0, 2, 13, 15.
